// File: rtl/sys_tx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sys_tx_ctrl_pkg
// Brief    : Shared widths, state encodings and tag constants for the
//            response-side TX controller. Optional macro: TX_FRAME_TAG_EN.
// Revision : 1.0
// ============================================================================
`ifndef SYS_DATA_WIDTH
`define SYS_DATA_WIDTH 8
`endif

package sys_tx_ctrl_pkg;

    localparam int c_WIDTH_DEF = `SYS_DATA_WIDTH;

`ifdef TX_FRAME_TAG_EN
    localparam logic [7:0] c_TAG_RD  = 8'hB0;
    localparam logic [7:0] c_TAG_ALU = 8'hC0;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SEND_RD     = 3'd1,
        ST_SEND_ALU_LO = 3'd2,
        ST_SEND_ALU_HI = 3'd3,
        ST_TAG         = 3'd4
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SEND_RD     = 2'd1,
        ST_SEND_ALU_LO = 2'd2,
        ST_SEND_ALU_HI = 2'd3
    } tx_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/sys_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sys_tx_ctrl_if
// Brief    : Response capture inputs and TX FIFO write-port bundle.
// Revision : 1.0
// ============================================================================
interface sys_tx_ctrl_if
    import sys_tx_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF
);
    logic [WIDTH-1:0]   RdData;
    logic               RdData_Valid;
    logic [2*WIDTH-1:0] ALU_OUT;
    logic               OUT_Valid;
    logic               FIFO_FULL;
    logic [WIDTH-1:0]   TX_P_DATA;
    logic               TX_D_VALID;
    logic               BUSY;
    logic               OVR;

    modport master (
        output RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
        input  TX_P_DATA, TX_D_VALID, BUSY, OVR
    );

    modport slave (
        input  RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
        output TX_P_DATA, TX_D_VALID, BUSY, OVR
    );
endinterface
`default_nettype wire

// File: rtl/sys_tx_ctrl_tx_resp_hold.sv
`default_nettype none
// ============================================================================
// Module   : tx_resp_hold
// Brief    : Single-entry holding register with pending flag and overrun flag.
// Revision : 1.0
// ============================================================================
module tx_resp_hold #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              strobe,
    input  logic [DATA_W-1:0] data,
    input  logic              consume,
    output logic [DATA_W-1:0] held,
    output logic              pend,
    output logic              overrun
);
    logic [DATA_W-1:0] r_data;
    logic              r_pend;

    // A strobe on the consume cycle refills the entry, so pend stays set.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data <= '0;
            r_pend <= 1'b0;
        end else if (strobe) begin
            r_data <= data;
            r_pend <= 1'b1;
        end else if (consume) begin
            r_pend <= 1'b0;
        end
    end

    assign held    = r_data;
    assign pend    = r_pend;
    assign overrun = strobe & r_pend & ~consume;
endmodule
`default_nettype wire

// File: rtl/sys_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sys_tx_ctrl
// Brief    : Buffers read/ALU responses and serialises them into TX FIFO
//            frames. Optional macro TX_FRAME_TAG_EN adds a leading tag frame.
// Revision : 1.0
// ============================================================================
module sys_tx_ctrl
    import sys_tx_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    sys_tx_ctrl_if.slave  bus
);
    tx_state_t          r_state;
    logic [WIDTH-1:0]   r_rd_shadow;
    logic [2*WIDTH-1:0] r_alu_shadow;
    logic               r_ovr;
`ifdef TX_FRAME_TAG_EN
    logic               r_tag_alu;
`endif

    logic [WIDTH-1:0]   w_rd_hold;
    logic [2*WIDTH-1:0] w_alu_hold;
    logic               w_rd_pend;
    logic               w_alu_pend;
    logic               w_rd_ovr;
    logic               w_alu_ovr;
    logic               w_rd_consume;
    logic               w_alu_consume;
    logic               w_send;
    logic               w_push;
    logic [WIDTH-1:0]   w_data;

    assign w_alu_consume = (r_state == ST_IDLE) && w_alu_pend;
    assign w_rd_consume  = (r_state == ST_IDLE) && w_rd_pend && !w_alu_pend;
    assign w_send        = (r_state != ST_IDLE);
    assign w_push        = w_send && !bus.FIFO_FULL;

    tx_resp_hold #(.DATA_W(WIDTH)) u_rd_hold (
        .CLK     (CLK),
        .RST     (RST),
        .strobe  (bus.RdData_Valid),
        .data    (bus.RdData),
        .consume (w_rd_consume),
        .held    (w_rd_hold),
        .pend    (w_rd_pend),
        .overrun (w_rd_ovr)
    );

    tx_resp_hold #(.DATA_W(2*WIDTH)) u_alu_hold (
        .CLK     (CLK),
        .RST     (RST),
        .strobe  (bus.OUT_Valid),
        .data    (bus.ALU_OUT),
        .consume (w_alu_consume),
        .held    (w_alu_hold),
        .pend    (w_alu_pend),
        .overrun (w_alu_ovr)
    );

    // Shadows are loaded when leaving IDLE, so later captures cannot
    // disturb a response already in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_rd_shadow  <= '0;
            r_alu_shadow <= '0;
            r_ovr        <= 1'b0;
`ifdef TX_FRAME_TAG_EN
            r_tag_alu    <= 1'b0;
`endif
        end else begin
            if (w_rd_ovr || w_alu_ovr)
                r_ovr <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_alu_pend) begin
                        r_alu_shadow <= w_alu_hold;
`ifdef TX_FRAME_TAG_EN
                        r_tag_alu    <= 1'b1;
                        r_state      <= ST_TAG;
`else
                        r_state      <= ST_SEND_ALU_LO;
`endif
                    end else if (w_rd_pend) begin
                        r_rd_shadow  <= w_rd_hold;
`ifdef TX_FRAME_TAG_EN
                        r_tag_alu    <= 1'b0;
                        r_state      <= ST_TAG;
`else
                        r_state      <= ST_SEND_RD;
`endif
                    end
                end
`ifdef TX_FRAME_TAG_EN
                ST_TAG: begin
                    if (w_push)
                        r_state <= r_tag_alu ? ST_SEND_ALU_LO : ST_SEND_RD;
                end
`endif
                ST_SEND_RD: begin
                    if (w_push)
                        r_state <= ST_IDLE;
                end
                ST_SEND_ALU_LO: begin
                    if (w_push)
                        r_state <= ST_SEND_ALU_HI;
                end
                ST_SEND_ALU_HI: begin
                    if (w_push)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_data = '0;
        case (r_state)
            ST_SEND_RD:     w_data = r_rd_shadow;
            ST_SEND_ALU_LO: w_data = r_alu_shadow[WIDTH-1:0];
            ST_SEND_ALU_HI: w_data = r_alu_shadow[2*WIDTH-1:WIDTH];
`ifdef TX_FRAME_TAG_EN
            ST_TAG:         w_data = r_tag_alu ? WIDTH'(c_TAG_ALU) : WIDTH'(c_TAG_RD);
`endif
            default:        w_data = '0;
        endcase
    end

    assign bus.TX_P_DATA  = w_data;
    assign bus.TX_D_VALID = w_push;
    assign bus.BUSY       = w_send || w_rd_pend || w_alu_pend;
    assign bus.OVR        = r_ovr;
endmodule
`default_nettype wire
